// File: rtl/multi_gate_occupancy.sv
// rtl/multi_gate_occupancy.sv - multi-gate vehicle direction detection and shared lot occupancy counter
//
// Purpose: watches NUM_GATES gates, each with an outer (A) / inner (B) photo-sensor
// pair. Each gate has a synchroniser and a direction FSM. Completed passages produce
// one-cycle enter/exit pulses, and a shared saturating counter tracks occupancy.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   sensors      raw sensor bits; gate g: bit 2g+1 = outer A, bit 2g = inner B (1 = blocked)
//   enter_pulse  one-cycle pulse per completed entry, one bit per gate
//   exit_pulse   one-cycle pulse per completed exit, one bit per gate
//   occupancy    current vehicle count, saturating at 0 and CAPACITY
//   full         occupancy == CAPACITY
//   empty        occupancy == 0
//   overflow     sticky: an entry was attempted while the lot was full
//   underflow    sticky: an exit was attempted while the lot was empty
module multi_gate_occupancy #(
  parameter int NUM_GATES   = 2,
  parameter int CAPACITY    = 3,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(CAPACITY + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*NUM_GATES-1:0] sensors,
  output logic [NUM_GATES-1:0]   enter_pulse,
  output logic [NUM_GATES-1:0]   exit_pulse,
  output logic [CW-1:0]          occupancy,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow
);

  // Signed sum width: enough headroom for occupancy plus/minus NUM_GATES events.
  localparam int SW = CW + $clog2(NUM_GATES) + 2;
  localparam logic [SW-1:0] CAP_SW = SW'(CAPACITY);
  localparam logic [CW-1:0] CAP_CW = CW'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    E1      = 3'd1,
    E2      = 3'd2,
    E3      = 3'd3,
    X1      = 3'd4,
    X2      = 3'd5,
    X3      = 3'd6,
    INVALID = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0][2*NUM_GATES-1:0] sync_q, sync_d;
  state_t                                  state_q [NUM_GATES];
  state_t                                  state_d [NUM_GATES];
  logic [NUM_GATES-1:0]                    enter_q, enter_d;
  logic [NUM_GATES-1:0]                    exit_q, exit_d;
  logic [CW-1:0]                           occ_q, occ_d;
  logic                                    ovf_q, ovf_d;
  logic                                    unf_q, unf_d;
  logic signed [SW-1:0]                    sum;

  // Direction FSM transition for one gate; values not listed hold the state.
  function automatic state_t next_state(input state_t s, input logic [1:0] ab);
    state_t n;
    n = s;
    case (s)
      IDLE:    case (ab) 2'b10: n = E1;   2'b01: n = X1;      2'b11: n = INVALID; default: n = s; endcase
      E1:      case (ab) 2'b11: n = E2;   2'b00: n = IDLE;    2'b01: n = INVALID; default: n = s; endcase
      E2:      case (ab) 2'b01: n = E3;   2'b10: n = E1;      2'b00: n = INVALID; default: n = s; endcase
      E3:      case (ab) 2'b00: n = IDLE; 2'b11: n = E2;      2'b10: n = INVALID; default: n = s; endcase
      X1:      case (ab) 2'b11: n = X2;   2'b00: n = IDLE;    2'b10: n = INVALID; default: n = s; endcase
      X2:      case (ab) 2'b10: n = X3;   2'b01: n = X1;      2'b00: n = INVALID; default: n = s; endcase
      X3:      case (ab) 2'b00: n = IDLE; 2'b11: n = X2;      2'b01: n = INVALID; default: n = s; endcase
      INVALID: if (ab == 2'b00) n = IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sensors;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Pulses fire on the transition back to IDLE from the final state of a passage,
  // so a gate can never raise both pulses in one cycle.
  always_comb begin
    enter_d = '0;
    exit_d  = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      state_d[g] = next_state(state_q[g], sync_q[SYNC_STAGES-1][2*g +: 2]);
      enter_d[g] = (state_q[g] == E3) && (sync_q[SYNC_STAGES-1][2*g +: 2] == 2'b00);
      exit_d[g]  = (state_q[g] == X3) && (sync_q[SYNC_STAGES-1][2*g +: 2] == 2'b00);
    end
  end

  // Entries and exits of one cycle net out before clamping.
  always_comb begin
    sum = SW'(occ_q);
    for (int g = 0; g < NUM_GATES; g++) begin
      sum = sum + SW'(enter_q[g]) - SW'(exit_q[g]);
    end
    occ_d = occ_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (sum[SW-1]) begin
      occ_d = '0;
      unf_d = 1'b1;
    end else if (sum > CAP_SW) begin
      occ_d = CAP_CW;
      ovf_d = 1'b1;
    end else begin
      occ_d = sum[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      enter_q <= '0;
      exit_q  <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int g = 0; g < NUM_GATES; g++) begin
        state_q[g] <= IDLE;
      end
    end else begin
      sync_q  <= sync_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int g = 0; g < NUM_GATES; g++) begin
        state_q[g] <= state_d[g];
      end
    end
  end

  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
  assign occupancy   = occ_q;
  assign full        = (occ_q == CAP_CW);
  assign empty       = (occ_q == '0);
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
